// File: rtl/nibble_serial_addsub_ctrl.sv
// Multi-precision add/subtract sequencer: one 4-bit ripple-carry slice is
// reused over WIDTH/4 cycles, least-significant nibble first, with a
// registered carry linking consecutive nibbles.
module nibble_serial_addsub_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_op_sub,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result,
    output logic             o_carry_out,
    output logic             o_overflow
);

    localparam int NSLICE = WIDTH / 4;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_opA;
    logic [WIDTH-1:0] r_opB;
    logic             r_carry;
    logic [IDXW-1:0]  r_idx;
    logic [WIDTH-1:0] r_result;
    logic             r_carryOut;
    logic             r_overflow;

    logic [3:0] w_nibA;
    logic [3:0] w_nibB;
    logic [3:0] w_lowSum;
    logic       w_carryInto3;
    logic [3:0] w_sliceSum;
    logic       w_sliceCarry;
    logic       w_lastSlice;

    // 4-bit slice split at bit 3 so the carry into the MSB is visible for overflow
    always_comb begin
        w_nibA       = r_opA[{r_idx, 2'b00} +: 4];
        w_nibB       = r_opB[{r_idx, 2'b00} +: 4];
        w_lowSum     = {1'b0, w_nibA[2:0]} + {1'b0, w_nibB[2:0]} + {3'b000, r_carry};
        w_carryInto3 = w_lowSum[3];
        w_sliceSum   = {w_nibA[3] ^ w_nibB[3] ^ w_carryInto3, w_lowSum[2:0]};
        w_sliceCarry = (w_nibA[3] & w_nibB[3]) | (w_nibA[3] & w_carryInto3)
                     | (w_nibB[3] & w_carryInto3);
        w_lastSlice  = (r_idx == IDXW'(NSLICE - 1));
    end

    // Sequencer: latch operands on start, run one nibble per cycle, then pulse done
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_opA      <= '0;
            r_opB      <= '0;
            r_carry    <= 1'b0;
            r_idx      <= '0;
            r_result   <= '0;
            r_carryOut <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_opA    <= i_a;
                        r_opB    <= i_op_sub ? ~i_b : i_b;
                        r_carry  <= i_op_sub;
                        r_idx    <= '0;
                        r_result <= '0;
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_result[{r_idx, 2'b00} +: 4] <= w_sliceSum;
                    r_carry <= w_sliceCarry;
                    r_idx   <= r_idx + IDXW'(1);
                    if (w_lastSlice) begin
                        r_carryOut <= w_sliceCarry;
                        r_overflow <= w_carryInto3 ^ w_sliceCarry;
                        r_state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs come straight from registers so no input reaches an output combinationally
    always_comb begin
        o_busy      = (r_state != S_IDLE);
        o_done      = (r_state == S_DONE);
        o_result    = r_result;
        o_carry_out = r_carryOut;
        o_overflow  = r_overflow;
    end

endmodule

// File: tb/tb_nibble_serial_addsub_ctrl.sv
// Directed-vector bench for the nibble-serial add/subtract sequencer (WIDTH=16).
module tb_nibble_serial_addsub_ctrl;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_start;
    logic        i_op_sub;
    logic [15:0] i_a;
    logic [15:0] i_b;
    logic        o_busy;
    logic        o_done;
    logic [15:0] o_result;
    logic        o_carry_out;
    logic        o_overflow;

    int checkCount = 0;
    int passCount  = 0;

    nibble_serial_addsub_ctrl #(.WIDTH(16)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_start     (i_start),
        .i_op_sub    (i_op_sub),
        .i_a         (i_a),
        .i_b         (i_b),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_result    (o_result),
        .o_carry_out (o_carry_out),
        .o_overflow  (o_overflow)
    );

    // 10-unit free-running clock
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Present an operation for exactly one edge, then scramble the operands
    task automatic applyStimulus(input logic sub, input logic [15:0] a, input logic [15:0] b);
        i_start  = 1'b1;
        i_op_sub = sub;
        i_a      = a;
        i_b      = b;
        tick();
        i_start  = 1'b0;
        i_op_sub = ~sub;
        i_a      = 16'($urandom);
        i_b      = 16'($urandom);
    endtask

    // Edges after the start edge until done is seen, bounded
    task automatic waitDone(output int edges);
        edges = 0;
        while (!o_done && edges < 20) begin
            tick();
            edges++;
        end
    endtask

    task automatic runOp(input string tag, input logic sub, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] expR,
                         input logic expC, input logic expV);
        int n;
        applyStimulus(sub, a, b);
        waitDone(n);
        checkOutput({tag, " latency"}, 32'(n), 32'd4);
        checkOutput({tag, " result"}, 32'(o_result), 32'(expR));
        checkOutput({tag, " carry"}, 32'(o_carry_out), 32'(expC));
        checkOutput({tag, " overflow"}, 32'(o_overflow), 32'(expV));
        tick();
        checkOutput({tag, " done low"}, 32'(o_done), 32'd0);
        checkOutput({tag, " busy low"}, 32'(o_busy), 32'd0);
    endtask

    initial begin
        int n;
        int doneCount;
        int firstDone;
        int secondDone;

        i_rst_n  = 1'b0;
        i_start  = 1'b0;
        i_op_sub = 1'b0;
        i_a      = 16'h0;
        i_b      = 16'h0;
        tick();
        tick();
        checkOutput("reset busy", 32'(o_busy), 32'd0);
        checkOutput("reset done", 32'(o_done), 32'd0);
        checkOutput("reset result", 32'(o_result), 32'd0);
        checkOutput("reset carry", 32'(o_carry_out), 32'd0);
        checkOutput("reset overflow", 32'(o_overflow), 32'd0);
        i_rst_n = 1'b1;
        tick();

        // Test 1: cycle-by-cycle latency of a simple add
        applyStimulus(1'b0, 16'h1234, 16'h0001);
        checkOutput("t1 busy e0", 32'(o_busy), 32'd1);
        checkOutput("t1 done e0", 32'(o_done), 32'd0);
        for (int k = 1; k <= 3; k++) begin
            tick();
            checkOutput($sformatf("t1 busy e%0d", k), 32'(o_busy), 32'd1);
            checkOutput($sformatf("t1 done e%0d", k), 32'(o_done), 32'd0);
        end
        tick();
        checkOutput("t1 busy e4", 32'(o_busy), 32'd1);
        checkOutput("t1 done e4", 32'(o_done), 32'd1);
        checkOutput("t1 result", 32'(o_result), 32'h1235);
        checkOutput("t1 carry", 32'(o_carry_out), 32'd0);
        checkOutput("t1 overflow", 32'(o_overflow), 32'd0);
        tick();
        checkOutput("t1 busy e5", 32'(o_busy), 32'd0);
        checkOutput("t1 done e5", 32'(o_done), 32'd0);
        checkOutput("t1 result held", 32'(o_result), 32'h1235);

        // Tests 2-4: arithmetic corner cases
        runOp("add ffff+1", 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0);
        runOp("add 7fff+1", 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1);
        runOp("add 8000+8000", 1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1);
        runOp("sub 5-3", 1'b1, 16'h0005, 16'h0003, 16'h0002, 1'b1, 1'b0);
        runOp("sub 3-5", 1'b1, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b0);
        runOp("sub 8000-1", 1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1);
        runOp("add 0a5c+39e7", 1'b0, 16'h0A5C, 16'h39E7, 16'h4443, 1'b0, 1'b0);

        // Test 5a: start pulsed mid-RUN is ignored
        applyStimulus(1'b0, 16'h1111, 16'h2222);
        tick();
        i_start = 1'b1;
        i_op_sub = 1'b1;
        i_a = 16'h9999;
        i_b = 16'h0001;
        tick();
        i_start = 1'b0;
        doneCount = 0;
        for (int k = 0; k < 10; k++) begin
            if (o_done) doneCount++;
            tick();
        end
        checkOutput("t5 single done", 32'(doneCount), 32'd1);
        checkOutput("t5 result kept", 32'(o_result), 32'h3333);

        // Test 5b: start held high gives back-to-back operations 6 edges apart
        i_start  = 1'b1;
        i_op_sub = 1'b0;
        i_a      = 16'h0001;
        i_b      = 16'h0002;
        firstDone  = -1;
        secondDone = -1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (o_done) begin
                if (firstDone < 0) begin
                    firstDone = k;
                    checkOutput("t5 b2b first result", 32'(o_result), 32'h0003);
                    i_a = 16'h0010;
                end else if (secondDone < 0) begin
                    secondDone = k;
                    checkOutput("t5 b2b second result", 32'(o_result), 32'h0012);
                end
            end
        end
        i_start = 1'b0;
        checkOutput("t5 b2b spacing", 32'(secondDone - firstDone), 32'd6);
        tick();
        tick();

        // Test 6: reset after the second slice aborts the operation
        applyStimulus(1'b0, 16'hFFFF, 16'hFFFF);
        tick();
        tick();
        i_rst_n = 1'b0;
        tick();
        checkOutput("t6 busy after rst", 32'(o_busy), 32'd0);
        checkOutput("t6 result after rst", 32'(o_result), 32'd0);
        checkOutput("t6 done after rst", 32'(o_done), 32'd0);
        i_rst_n = 1'b1;
        doneCount = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (o_done) doneCount++;
        end
        checkOutput("t6 no done pulse", 32'(doneCount), 32'd0);
        runOp("t6 post-reset", 1'b1, 16'h1000, 16'h0001, 16'h0FFF, 1'b1, 1'b0);

        // A start that never completes would be caught by waitDone's bound
        applyStimulus(1'b0, 16'h00FF, 16'h0001);
        waitDone(n);
        checkOutput("final latency", 32'(n), 32'd4);
        checkOutput("final result", 32'(o_result), 32'h0100);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
